// File: rtl/bus_master_interface.sv
// bus_master_interface
//   Initiator side of the shared system bus. Takes one read/write request at a time
//   from a core-side valid/ready port, drives the bus, then waits for the addressed
//   responder to raise fc_bus. It returns read data, or an error if the access times out.
//   Ports:
//     clk, rst                        clock, async active-high reset
//     req_valid/req_ready             core request handshake (req_ready is high when idle)
//     req_write/addr/wdata/mask       request payload
//     resp_valid/resp_rdata/resp_error  one-cycle completion pulse, data, timeout flag
//     addr_bus/data_bus/rd_bus/wr_bus/data_mask_bus  registered bus drive
//     fc_bus                          function-complete from the responder
module bus_master_interface #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_mask,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] addr_bus,
   inout  wire  [31:0] data_bus,
   output logic        rd_bus,
   output logic        wr_bus,
   output logic [3:0]  data_mask_bus,
   input  logic        fc_bus
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       mask_q, mask_d;
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_rdata_q, resp_rdata_d;
   logic             resp_error_q, resp_error_d;

   // State and registered bus/response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         mask_q       <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         mask_q       <= mask_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
      end
   end

   // Next-state logic. Bus values are loaded on the edge that enters ACCESS and
   // cleared on the edge that leaves it, so the bus pins come straight from flops.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      mask_d       = mask_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               mask_d  = req_mask;
               rd_d    = ~req_write;
               wr_d    = req_write;
               wdata_d = req_wdata;
               cnt_d   = '0;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            // A completion on the last allowed cycle takes priority over the timeout
            if (fc_bus || (cnt_q == CNT_LAST)) begin
               resp_rdata_d = (fc_bus && rd_q) ? data_bus : 32'h0;
               resp_error_d = ~fc_bus;
               resp_valid_d = 1'b1;
               addr_d       = '0;
               mask_d       = '0;
               rd_d         = 1'b0;
               wr_d         = 1'b0;
               state_d      = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = resp_rdata_q;
   assign resp_error    = resp_error_q;
   assign addr_bus      = addr_q;
   assign data_mask_bus = mask_q;
   assign rd_bus        = rd_q;
   assign wr_bus        = wr_q;
   // The data bus is only ever driven while a write is on the bus
   assign data_bus      = wr_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_bus_master_interface.sv
`timescale 1ns/1ps
module tb_bus_master_interface;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_mask = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] addr_bus;
   wire  [31:0] data_bus;
   logic        rd_bus;
   logic        wr_bus;
   logic [3:0]  data_mask_bus;
   wire         fc_bus;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_master_interface #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
      .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
   );

   // Responder model: two word registers at 0x0/0x4 (combinational fc on reads,
   // registered fc on writes), a slow responder at 0x200 that completes on the
   // 16th access cycle, and nothing anywhere else.
   logic [31:0] regs [0:1];
   logic        fc_wr_q;
   logic [4:0]  late_cnt;
   logic        pl_en = 1'b0;
   logic        pl_idx = 1'b0;
   logic [31:0] pl_val = '0;
   wire         mapped   = (addr_bus < 32'd8);
   wire         late_hit = (addr_bus == 32'h200);
   wire         fc_late  = rd_bus && late_hit && (late_cnt == 5'd15);
   assign fc_bus   = (rd_bus && mapped) | fc_wr_q | fc_late;
   assign data_bus = (rd_bus && mapped)   ? regs[addr_bus[2]] :
                     (rd_bus && late_hit) ? 32'hCAFEF00D : 32'bz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fc_wr_q  <= 1'b0;
         late_cnt <= '0;
      end else begin
         fc_wr_q  <= wr_bus && mapped && !fc_wr_q;
         late_cnt <= (rd_bus && late_hit) ? late_cnt + 5'd1 : 5'd0;
      end
   end

   always @(posedge clk) begin
      if (pl_en) regs[pl_idx] <= pl_val;
      else if (wr_bus && mapped && !fc_wr_q) begin
         for (int i = 0; i < 4; i++) begin
            if (data_mask_bus[i] && (i + int'(addr_bus[1:0])) < 4)
               regs[addr_bus[2]][8*(i+int'(addr_bus[1:0])) +: 8] <= data_bus[8*i +: 8];
         end
      end
   end

   // Bus monitor: cycle counts and the last write seen on the bus
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_data_seen = '0;
   logic [31:0] wr_addr_seen = '0;
   logic [3:0]  wr_mask_seen = '0;
   logic        both_seen = 1'b0;
   always @(negedge clk) begin
      if (rd_bus) rd_cnt++;
      if (wr_bus) begin
         wr_cnt++;
         wr_data_seen = data_bus;
         wr_addr_seen = addr_bus;
         wr_mask_seen = data_mask_bus;
      end
      if (rd_bus && wr_bus) both_seen = 1'b1;
   end

   logic [31:0] t_rdata;
   logic        t_err;
   int          t_lat, t_rdc, t_wrc;

   task automatic preload(input logic idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_val = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Issue one request from idle and wait (bounded) for its response
   task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
      int rd0, wr0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_mask = m;
      rd0 = rd_cnt; wr0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      t_lat = 1;
      while (!resp_valid && t_lat < 40) begin
         @(negedge clk);
         t_lat++;
      end
      t_rdata = resp_rdata; t_err = resp_error;
      t_rdc = rd_cnt - rd0; t_wrc = wr_cnt - wr0;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
      n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL reset_resp_error got %b want 0", resp_error); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
      n_checks++; if (addr_bus !== 32'h0) begin n_fail++; $display("FAIL reset_addr_bus got %h want 0", addr_bus); end
      n_checks++; if ({rd_bus, wr_bus} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {rd_bus, wr_bus}); end
      n_checks++; if (data_mask_bus !== 4'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", data_mask_bus); end
      rst = 1'b0;
   endtask

   task automatic test_read();
      preload(1'b1, 32'hA5A50001);
      run_txn(1'b0, 32'h4, 32'h0, 4'hF);
      n_checks++; if (t_lat !== 2) begin n_fail++; $display("FAIL read_latency got %0d want 2", t_lat); end
      n_checks++; if (t_rdc !== 1) begin n_fail++; $display("FAIL read_rd_cycles got %0d want 1", t_rdc); end
      n_checks++; if (t_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL read_rdata got %h want a5a50001", t_rdata); end
      n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL read_error got %b want 0", t_err); end
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL read_ready_c3 got %b want 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_pulse got %b want 0", resp_valid); end
      n_checks++; if (resp_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL read_rdata_hold got %h want a5a50001", resp_rdata); end
   endtask

   task automatic test_write();
      run_txn(1'b1, 32'h4, 32'h00000101, 4'hF);
      n_checks++; if (t_lat !== 3) begin n_fail++; $display("FAIL write_latency got %0d want 3", t_lat); end
      n_checks++; if (t_wrc !== 2) begin n_fail++; $display("FAIL write_wr_cycles got %0d want 2", t_wrc); end
      n_checks++; if (wr_data_seen !== 32'h00000101) begin n_fail++; $display("FAIL write_data_bus got %h want 00000101", wr_data_seen); end
      n_checks++; if (regs[1] !== 32'h00000101) begin n_fail++; $display("FAIL write_target got %h want 00000101", regs[1]); end
      n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL write_error got %b want 0", t_err); end
      n_checks++; if (t_rdata !== 32'h0) begin n_fail++; $display("FAIL write_rdata got %h want 0", t_rdata); end
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 32'h100, 32'h0, 4'hF);
      n_checks++; if (t_lat !== 17) begin n_fail++; $display("FAIL timeout_latency got %0d want 17", t_lat); end
      n_checks++; if (t_rdc !== 16) begin n_fail++; $display("FAIL timeout_rd_cycles got %0d want 16", t_rdc); end
      n_checks++; if (t_err !== 1'b1) begin n_fail++; $display("FAIL timeout_error got %b want 1", t_err); end
      n_checks++; if (t_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata got %h want 0", t_rdata); end
   endtask

   task automatic test_fc_at_timeout();
      run_txn(1'b0, 32'h200, 32'h0, 4'hF);
      n_checks++; if (t_lat !== 17) begin n_fail++; $display("FAIL late_fc_latency got %0d want 17", t_lat); end
      n_checks++; if (t_rdc !== 16) begin n_fail++; $display("FAIL late_fc_rd_cycles got %0d want 16", t_rdc); end
      n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL late_fc_error got %b want 0", t_err); end
      n_checks++; if (t_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL late_fc_rdata got %h want cafef00d", t_rdata); end
   endtask

   task automatic test_back_to_back();
      logic [8:1] exp_wr, exp_rv, exp_rdy;
      exp_wr  = 8'b0011_0011;   // bit i = cycle i, LSB side is cycle 1
      exp_rv  = 8'b0100_0100;
      exp_rdy = 8'b1000_1000;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hDEAD0000; req_mask = 4'hF;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) begin req_addr = 32'h4; req_wdata = 32'h0000BEEF; end
         n_checks++; if (wr_bus !== exp_wr[i]) begin n_fail++; $display("FAIL b2b_wr_c%0d got %b want %b", i, wr_bus, exp_wr[i]); end
         n_checks++; if (resp_valid !== exp_rv[i]) begin n_fail++; $display("FAIL b2b_valid_c%0d got %b want %b", i, resp_valid, exp_rv[i]); end
         n_checks++; if (req_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL b2b_ready_c%0d got %b want %b", i, req_ready, exp_rdy[i]); end
         if (exp_rv[i]) begin
            n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL b2b_error_c%0d got %b want 0", i, resp_error); end
         end
         if (i == 5) req_valid = 1'b0;
      end
      n_checks++; if (regs[0] !== 32'hDEAD0000) begin n_fail++; $display("FAIL b2b_first got %h want dead0000", regs[0]); end
      n_checks++; if (regs[1] !== 32'h0000BEEF) begin n_fail++; $display("FAIL b2b_second got %h want 0000beef", regs[1]); end
   endtask

   task automatic test_reset_mid_write();
      logic rv_seen;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h12345678; req_mask = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (wr_bus !== 1'b1) begin n_fail++; $display("FAIL abort_pre_wr got %b want 1", wr_bus); end
      rst = 1'b1;
      #1;
      n_checks++; if (wr_bus !== 1'b0) begin n_fail++; $display("FAIL abort_wr got %b want 0", wr_bus); end
      n_checks++; if (addr_bus !== 32'h0) begin n_fail++; $display("FAIL abort_addr got %h want 0", addr_bus); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", req_ready); end
      rv_seen = resp_valid;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rv_seen |= resp_valid;
      end
      n_checks++; if (rv_seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_resp got %b want 0", rv_seen); end
      run_txn(1'b0, 32'h0, 32'h0, 4'hF);
      n_checks++; if (t_lat !== 2) begin n_fail++; $display("FAIL abort_read_latency got %0d want 2", t_lat); end
      n_checks++; if (t_rdata !== 32'h12345678) begin n_fail++; $display("FAIL abort_read_rdata got %h want 12345678", t_rdata); end
      n_checks++; if (t_err !== 1'b0) begin n_fail++; $display("FAIL abort_read_error got %b want 0", t_err); end
   endtask

   task automatic test_unaligned();
      preload(1'b1, 32'h11223344);
      run_txn(1'b1, 32'h6, 32'h000000FF, 4'b0001);
      n_checks++; if (wr_addr_seen !== 32'h6) begin n_fail++; $display("FAIL unal_addr got %h want 6", wr_addr_seen); end
      n_checks++; if (wr_mask_seen !== 4'b0001) begin n_fail++; $display("FAIL unal_mask got %b want 0001", wr_mask_seen); end
      n_checks++; if (regs[1] !== 32'h11FF3344) begin n_fail++; $display("FAIL unal_target got %h want 11ff3344", regs[1]); end
      run_txn(1'b0, 32'h4, 32'h0, 4'hF);
      n_checks++; if (t_rdata !== 32'h11FF3344) begin n_fail++; $display("FAIL unal_readback got %h want 11ff3344", t_rdata); end
      n_checks++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL strobe_exclusive got %b want 0", both_seen); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_timeout();
      test_fc_at_timeout();
      test_back_to_back();
      test_reset_mid_write();
      test_unaligned();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
